// File: rtl/decode_stage.sv
// Decode/register-fetch stage: register file, operand bypass, hazard stall and branch/jump decode.
// Optional feature macro: BYPASS_EN enables ALU/MEM/WB operand forwarding (undefined: stall until written back).
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif
`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 32'h8000_0000
`endif

module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic [31:0] ir_next,
    input  logic        irq_in,
    input  logic        alu_we,
    input  logic        mem_we,
    input  logic        wb_we,
    input  logic [4:0]  alu_rc,
    input  logic [4:0]  mem_rc,
    input  logic [4:0]  wb_rc,
    input  logic [31:0] alu_data,
    input  logic [31:0] mem_data,
    input  logic [31:0] wb_data,
    input  logic        alu_ld,
    output logic        stall,
    output logic        zr,
    output logic        irq,
    output logic        ill_op,
    output logic        op_jmp,
    output logic        op_beq,
    output logic        op_bne,
    output logic [1:0]  ir_src_rf,
    output logic [31:0] br_addr,
    output logic [31:0] j_addr,
    output logic [31:0] pc_alu,
    output logic [31:0] ir_alu,
    output logic [31:0] a_alu,
    output logic [31:0] b_alu,
    output logic [31:0] d_alu
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RADDRW = 5;
    localparam int unsigned NREGS  = 32;
    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1D;
    localparam logic [5:0] OP_BNE = 6'h1E;
    localparam logic [5:0] OP_LDR = 6'h1F;
    localparam logic [RADDRW-1:0] R_ZERO = RADDRW'(31);

    logic [XLEN-1:0]   pc_rf, ir_rf;
    logic [XLEN-1:0]   regs [NREGS];
    logic [5:0]        op;
    logic [RADDRW-1:0] rc, ra, rb, b_addr;
    logic [XLEN-1:0]   lit, rf_a, rf_b, a_val, b_val, b_next, d_next;
    logic is_ld, is_st, is_jmp, is_beq, is_bne, is_ldr, is_alu, is_alu_lit, legal;
    logic a_used, b_used, ctl_ok;

    // A stage forwards to a port when it writes the same, non-R31, register
    function automatic logic hit(input logic we, input logic [RADDRW-1:0] src,
                                 input logic [RADDRW-1:0] addr);
        return we && (src == addr) && (addr != R_ZERO);
    endfunction

    assign op     = ir_rf[31:26];
    assign rc     = ir_rf[25:21];
    assign ra     = ir_rf[20:16];
    assign rb     = ir_rf[15:11];
    assign lit    = {{16{ir_rf[15]}}, ir_rf[15:0]};

    assign is_ld      = (op == OP_LD);
    assign is_st      = (op == OP_ST);
    assign is_jmp     = (op == OP_JMP);
    assign is_beq     = (op == OP_BEQ);
    assign is_bne     = (op == OP_BNE);
    assign is_ldr     = (op == OP_LDR);
    assign is_alu     = op[5] && (op[3:0] != 4'h7) && (op[3:0] != 4'hF);
    assign is_alu_lit = is_alu && op[4];
    assign legal      = is_ld | is_st | is_jmp | is_beq | is_bne | is_ldr | is_alu;

    assign a_used = legal && !is_ldr;
    assign b_used = is_st || (is_alu && !op[4]);
    assign b_addr = is_st ? rc : rb;

    assign rf_a = (ra == R_ZERO) ? '0 : regs[ra];
    assign rf_b = (b_addr == R_ZERO) ? '0 : regs[b_addr];

`ifdef BYPASS_EN
    always_comb begin
        if (hit(alu_we, alu_rc, ra))      a_val = alu_data;
        else if (hit(mem_we, mem_rc, ra)) a_val = mem_data;
        else if (hit(wb_we, wb_rc, ra))   a_val = wb_data;
        else                              a_val = rf_a;
    end

    always_comb begin
        if (hit(alu_we, alu_rc, b_addr))      b_val = alu_data;
        else if (hit(mem_we, mem_rc, b_addr)) b_val = mem_data;
        else if (hit(wb_we, wb_rc, b_addr))   b_val = wb_data;
        else                                  b_val = rf_b;
    end

    // Only a load in the ALU stage cannot be forwarded in time
    assign stall = alu_ld && ((a_used && hit(alu_we, alu_rc, ra)) ||
                              (b_used && hit(alu_we, alu_rc, b_addr)));
`else
    logic unused_fwd;

    assign a_val = rf_a;
    assign b_val = rf_b;
    assign unused_fwd = ^{alu_data, mem_data, alu_ld};

    // Without forwarding, wait until every in-flight producer has written back
    assign stall = (a_used && (hit(alu_we, alu_rc, ra) || hit(mem_we, mem_rc, ra) ||
                               hit(wb_we, wb_rc, ra))) ||
                   (b_used && (hit(alu_we, alu_rc, b_addr) || hit(mem_we, mem_rc, b_addr) ||
                               hit(wb_we, wb_rc, b_addr)));
`endif

    assign ill_op  = !legal && !stall;
    assign irq     = irq_in && !pc_rf[31] && !stall;
    assign ctl_ok  = !stall && !ill_op && !irq;
    assign op_jmp  = is_jmp && ctl_ok;
    assign op_beq  = is_beq && ctl_ok;
    assign op_bne  = is_bne && ctl_ok;
    assign zr      = (a_val == '0);
    assign br_addr = pc_rf + {lit[29:0], 2'b00};
    // User-mode code may not jump into the supervisor half of the address space
    assign j_addr  = {a_val[31] & pc_rf[31], a_val[30:2], 2'b00};

    always_comb begin
        ir_src_rf = `IR_SRC_DATA;
        if (irq || ill_op)
            ir_src_rf = `IR_SRC_EXCEPT;
        else if (op_jmp || (op_beq && zr) || (op_bne && !zr))
            ir_src_rf = `IR_SRC_NOP;
    end

    always_comb begin
        b_next = b_val;
        if (is_ldr)
            b_next = {lit[29:0], 2'b00};
        else if (is_alu_lit || is_ld || is_st)
            b_next = lit;
    end

    always_comb begin
        d_next = '0;
        if (is_st)
            d_next = b_val;
        else if (is_jmp || is_beq || is_bne)
            d_next = pc_rf;
    end

    // IF/RF pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_rf <= `PC_RESET_ADDR;
            ir_rf <= `INST_NOP;
        end else if (!stall) begin
            pc_rf <= pc_next;
            ir_rf <= ir_next;
        end
    end

    // Register file write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wb_we && (wb_rc != R_ZERO))
            regs[wb_rc] <= wb_data;
    end

    // RF/ALU pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_alu <= `INST_NOP;
            pc_alu <= '0;
            a_alu  <= '0;
            b_alu  <= '0;
            d_alu  <= '0;
        end else begin
            if (stall || ill_op) begin
                ir_alu <= `INST_NOP;
            end else begin
                ir_alu <= ir_rf;
                pc_alu <= pc_rf;
            end
            a_alu <= is_ldr ? pc_rf : a_val;
            b_alu <= b_next;
            d_alu <= d_next;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_stage;
    localparam logic [31:0] NOP_I   = 32'h83FF_F800;
    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam logic [1:0]  S_DATA  = 2'd0;
    localparam logic [1:0]  S_NOP   = 2'd1;
    localparam logic [1:0]  S_EXC   = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next, ir_next;
    logic        irq_in, alu_we, mem_we, wb_we, alu_ld;
    logic [4:0]  alu_rc, mem_rc, wb_rc;
    logic [31:0] alu_data, mem_data, wb_data;
    logic        stall, zr, irq, ill_op, op_jmp, op_beq, op_bne;
    logic [1:0]  ir_src_rf;
    logic [31:0] br_addr, j_addr, pc_alu, ir_alu, a_alu, b_alu, d_alu;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .ir_next(ir_next), .irq_in(irq_in),
        .alu_we(alu_we), .mem_we(mem_we), .wb_we(wb_we),
        .alu_rc(alu_rc), .mem_rc(mem_rc), .wb_rc(wb_rc),
        .alu_data(alu_data), .mem_data(mem_data), .wb_data(wb_data), .alu_ld(alu_ld),
        .stall(stall), .zr(zr), .irq(irq), .ill_op(ill_op),
        .op_jmp(op_jmp), .op_beq(op_beq), .op_bne(op_bne), .ir_src_rf(ir_src_rf),
        .br_addr(br_addr), .j_addr(j_addr), .pc_alu(pc_alu), .ir_alu(ir_alu),
        .a_alu(a_alu), .b_alu(b_alu), .d_alu(d_alu)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_rf [32];
    logic [31:0] m_pc_rf, m_ir_rf, m_pc_alu, m_ir_alu, m_a, m_b, m_d;
    bit          m_valid = 0;

    // Expected combinational outputs for the current cycle
    bit          e_stall, e_zr, e_irq, e_ill, e_jmp, e_beq, e_bne;
    logic [1:0]  e_src;
    logic [31:0] e_br, e_j, e_aval, e_bval, e_anext, e_bnext, e_dnext;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rc, input int ra, input int low16);
        return {6'(op), 5'(rc), 5'(ra), 16'(low16)};
    endfunction

    function automatic logic [31:0] enc_r(input int op, input int rc, input int ra, input int rb);
        return {6'(op), 5'(rc), 5'(ra), 5'(rb), 11'd0};
    endfunction

    // Value a read port sees for register r this cycle
    function automatic logic [31:0] read_port(input int r);
        if (r == 31) return 32'd0;
`ifdef BYPASS_EN
        if (alu_we && int'(alu_rc) == r) return alu_data;
        if (mem_we && int'(mem_rc) == r) return mem_data;
        if (wb_we && int'(wb_rc) == r) return wb_data;
`endif
        return m_rf[r];
    endfunction

    task automatic model_eval();
        int op, rc, ra, rb, baddr;
        int used[$];
        bit legal, alu_op, alu_lit, br_kind;
        logic [31:0] lit;
        logic we_s[3];
        int rc_s[3];
        op = int'(m_ir_rf[31:26]);
        rc = int'(m_ir_rf[25:21]);
        ra = int'(m_ir_rf[20:16]);
        rb = int'(m_ir_rf[15:11]);
        lit = {{16{m_ir_rf[15]}}, m_ir_rf[15:0]};
        alu_op  = (op >= 32) && (op % 16 != 7) && (op % 16 != 15);
        alu_lit = alu_op && (op >= 48);
        legal   = alu_op || op == 24 || op == 25 || op == 27 || op == 29 || op == 30 || op == 31;
        baddr   = (op == 25) ? rc : rb;
        if (legal && op != 31) used.push_back(ra);
        if (op == 25) used.push_back(rc);
        if (alu_op && !alu_lit) used.push_back(rb);
        we_s[0] = alu_we; we_s[1] = mem_we; we_s[2] = wb_we;
        rc_s[0] = int'(alu_rc); rc_s[1] = int'(mem_rc); rc_s[2] = int'(wb_rc);
        e_stall = 0;
        foreach (used[i]) begin
`ifdef BYPASS_EN
            if (alu_ld && alu_we && int'(alu_rc) != 31 && int'(alu_rc) == used[i]) e_stall = 1;
`else
            for (int s = 0; s < 3; s++)
                if (we_s[s] && rc_s[s] != 31 && rc_s[s] == used[i]) e_stall = 1;
`endif
        end
        e_aval = read_port(ra);
        e_bval = read_port(baddr);
        e_ill  = !legal && !e_stall;
        e_irq  = irq_in && m_pc_rf < 32'h8000_0000 && !e_stall;
        br_kind = !e_stall && !e_ill && !e_irq;
        e_jmp  = br_kind && op == 27;
        e_beq  = br_kind && op == 29;
        e_bne  = br_kind && op == 30;
        e_zr   = (e_aval == 0);
        e_br   = m_pc_rf + lit * 4;
        e_j    = e_aval & 32'hFFFF_FFFC;
        if (m_pc_rf < 32'h8000_0000) e_j = e_j & 32'h7FFF_FFFF;
        if (e_irq || e_ill) e_src = S_EXC;
        else if (e_jmp || (e_beq && e_zr) || (e_bne && !e_zr)) e_src = S_NOP;
        else e_src = S_DATA;
        e_anext = (op == 31) ? m_pc_rf : e_aval;
        if (op == 31) e_bnext = lit * 4;
        else if (alu_lit || op == 24 || op == 25) e_bnext = lit;
        else e_bnext = e_bval;
        if (op == 25) e_dnext = e_bval;
        else if (op == 27 || op == 29 || op == 30) e_dnext = m_pc_rf;
        else e_dnext = 0;
    endtask

    task automatic compare_all();
        check("stall", 32'(stall), 32'(e_stall));
        check("ill_op", 32'(ill_op), 32'(e_ill));
        check("irq", 32'(irq), 32'(e_irq));
        check("op_jmp", 32'(op_jmp), 32'(e_jmp));
        check("op_beq", 32'(op_beq), 32'(e_beq));
        check("op_bne", 32'(op_bne), 32'(e_bne));
        check("zr", 32'(zr), 32'(e_zr));
        check("ir_src_rf", 32'(ir_src_rf), 32'(e_src));
        check("br_addr", br_addr, e_br);
        check("j_addr", j_addr, e_j);
        check("pc_alu", pc_alu, m_pc_alu);
        check("ir_alu", ir_alu, m_ir_alu);
        check("a_alu", a_alu, m_a);
        check("b_alu", b_alu, m_b);
        check("d_alu", d_alu, m_d);
    endtask

    // Move to mid-cycle, evaluate the model and compare against the DUT
    task automatic settle();
        @(negedge clk);
        model_eval();
        if (m_valid) compare_all();
    endtask

    // Apply this cycle's clock edge to the model, then step to just after the edge
    task automatic advance();
        if (rst) begin
            m_pc_rf = RST_PC; m_ir_rf = NOP_I; m_ir_alu = NOP_I;
            m_pc_alu = 0; m_a = 0; m_b = 0; m_d = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (e_stall || e_ill) m_ir_alu = NOP_I;
            else begin m_ir_alu = m_ir_rf; m_pc_alu = m_pc_rf; end
            m_a = e_anext; m_b = e_bnext; m_d = e_dnext;
            if (!e_stall) begin m_pc_rf = pc_next; m_ir_rf = ir_next; end
        end
        if (wb_we && wb_rc != 5'd31) m_rf[wb_rc] = wb_data;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rst = 0; irq_in = 0; alu_ld = 0;
        alu_we = 0; mem_we = 0; wb_we = 0;
        alu_rc = 5'd31; mem_rc = 5'd31; wb_rc = 5'd31;
        alu_data = 0; mem_data = 0; wb_data = 0;
        ir_next = NOP_I; pc_next = 32'h0000_0400;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        foreach (m_rf[i]) m_rf[i] = 0;
        idle();
        rst = 1;
        step();
        step();
        // Reset state
        settle();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ill", 32'(ill_op), 32'd0);
        check("rst_src", 32'(ir_src_rf), 32'(S_DATA));
        check("rst_ir_alu", ir_alu, NOP_I);
        check("rst_a_alu", a_alu, 32'd0);
        advance();

        rst = 0;
        for (int r = 0; r < 31; r++) begin
            wb_we = 1; wb_rc = 5'(r); wb_data = $urandom;
            step();
        end
        idle();

        // Write-back then read in RF
        wb_we = 1; wb_rc = 5'd5; wb_data = 32'h1234; ir_next = enc_r(6'h20, 6, 5, 5);
        step();
        idle();
        step();
        settle();
        check("d36_a", a_alu, 32'h1234);
        check("d36_b", b_alu, 32'h1234);
        advance();
        wb_we = 1; wb_rc = 5'd31; wb_data = 32'hDEAD_BEEF; ir_next = enc_r(6'h20, 7, 31, 31);
        step();
        idle();
        step();
        settle();
        check("d36_r31", a_alu, 32'd0);
        advance();

        // ALU result has priority over MEM for forwarding
        ir_next = enc(6'h30, 1, 3, 1);
        step();
        idle();
        alu_we = 1; alu_rc = 5'd3; alu_data = 7; mem_we = 1; mem_rc = 5'd3; mem_data = 9;
`ifdef BYPASS_EN
        step();
        idle();
        settle();
        check("d37_a", a_alu, 32'd7);
        check("d37_b", b_alu, 32'd1);
        advance();
`else
        settle();
        check("d37_stall", 32'(stall), 32'd1);
        advance();
        idle();
        step();
        step();
`endif

        // Load-use hazard
        idle();
        ir_next = enc_r(6'h21, 4, 2, 1);
        step();
        idle();
        alu_ld = 1; alu_we = 1; alu_rc = 5'd2; alu_data = 32'hAAAA;
        settle();
        check("d38_stall", 32'(stall), 32'd1);
        advance();
        idle();
        mem_we = 1; mem_rc = 5'd2; mem_data = 32'h5555;
        settle();
        check("d38_bubble", ir_alu, NOP_I);
        advance();
        idle();
`ifdef BYPASS_EN
        settle();
        check("d38_a", a_alu, 32'h5555);
        advance();
`else
        wb_we = 1; wb_rc = 5'd2; wb_data = 32'h5555;
        step();
        idle();
        step();
        settle();
        check("d38_a", a_alu, 32'h5555);
        advance();
`endif

        // BEQ taken, link data and branch target
        idle();
        wb_we = 1; wb_rc = 5'd0; wb_data = 0;
        pc_next = 32'h100; ir_next = enc(6'h1D, 31, 0, 16'hFFFE);
        step();
        idle();
        settle();
        check("d39_beq", 32'(op_beq), 32'd1);
        check("d39_zr", 32'(zr), 32'd1);
        check("d39_br", br_addr, 32'h0000_00F8);
        check("d39_src", 32'(ir_src_rf), 32'(S_NOP));
        advance();
        settle();
        check("d39_d", d_alu, 32'h100);
        advance();

        // Illegal opcode
        ir_next = 32'h0000_0000;
        step();
        idle();
        settle();
        check("d40_ill", 32'(ill_op), 32'd1);
        check("d40_src", 32'(ir_src_rf), 32'(S_EXC));
        advance();
        settle();
        check("d40_ir_alu", ir_alu, NOP_I);
        advance();

        // Interrupts only in user mode
        pc_next = 32'h200;
        step();
        idle();
        irq_in = 1; pc_next = 32'h8000_0200;
        settle();
        check("d41_irq", 32'(irq), 32'd1);
        check("d41_src", 32'(ir_src_rf), 32'(S_EXC));
        advance();
        idle();
        irq_in = 1;
        settle();
        check("d41_sup", 32'(irq), 32'd0);
        advance();

        // User-mode jump cannot reach supervisor space
        idle();
        wb_we = 1; wb_rc = 5'd8; wb_data = 32'hFFFF_FFFF;
        step();
        idle();
        pc_next = 32'h300; ir_next = enc(6'h1B, 31, 8, 0);
        step();
        idle();
        settle();
        check("jmp_user", j_addr, 32'h7FFF_FFFC);
        advance();

        // Reset during a stall
        ir_next = enc_r(6'h21, 4, 2, 1);
        step();
        idle();
        alu_ld = 1; alu_we = 1; alu_rc = 5'd2; mem_we = 1; mem_rc = 5'd1;
        settle();
        check("rst_mid_stall", 32'(stall), 32'd1);
        advance();
        rst = 1;
        step();
        settle();
        check("rst_clears_stall", 32'(stall), 32'd0);
        advance();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int sel, opc;
            sel = $urandom_range(0, 9);
            case (sel)
                0: opc = 6'h18;
                1: opc = 6'h19;
                2: opc = 6'h1B;
                3: opc = 6'h1D;
                4: opc = 6'h1E;
                5: opc = 6'h1F;
                6: opc = $urandom_range(0, 63);
                default: opc = $urandom_range(32, 63);
            endcase
            rst = ($urandom_range(0, 199) == 0);
            ir_next = {6'(opc),
                       ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                       11'($urandom)};
            pc_next = $urandom;
            irq_in = ($urandom_range(0, 7) == 0);
            alu_ld = ($urandom_range(0, 2) == 0);
            alu_we = $urandom_range(0, 1); alu_rc = 5'($urandom_range(0, 8));
            mem_we = $urandom_range(0, 1); mem_rc = 5'($urandom_range(0, 8));
            wb_we = $urandom_range(0, 1);
            wb_rc = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 8));
            alu_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            mem_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            wb_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 pc_next, ir_next  in  32 each  PC+4 and instruction from fetch.
REQ-004 irq_in  in  1  raw interrupt request.
REQ-005 alu_we/mem_we/wb_we  in  1 each  stage writes a register.
REQ-006 alu_rc/mem_rc/wb_rc  in  5 each  destination register of that stage.
REQ-007 alu_data/mem_data/wb_data  in  32 each  result of that stage; wb_* is also the register-file write port.
REQ-008 alu_ld  in  1  ALU-stage instruction is LD or LDR.
REQ-009 stall, zr, irq, ill_op, op_jmp, op_beq, op_bne  out  1 each  fetch control.
REQ-010 ir_src_rf  out  2  fetch IR source select (`IR_SRC_DATA / `IR_SRC_NOP / `IR_SRC_EXCEPT).
REQ-011 br_addr, j_addr  out  32 each  branch and jump targets.
REQ-012 pc_alu, ir_alu, a_alu, b_alu, d_alu  out  32 each  registered ALU-stage PC+4, instruction, operand A, operand B, store/link data.

Function
REQ-013 IF/RF register: ~stall -> pc_rf<=pc_next, ir_rf<=ir_next; stall -> hold.
REQ-014 Fields: op=ir_rf[31:26], rc=[25:21], ra=[20:16], rb=[15:11], lit=sext(ir_rf[15:0]).
REQ-015 Register file 32x32, 2 read/1 write; write on edge when wb_we & wb_rc!=31; R31 always reads 0; contents not reset.
REQ-016 Port A reads ra (used by all ops except LDR); port B reads rc for ST, rb for register-form ALU ops; unused otherwise.
REQ-017 Bypass per port, priority ALU > MEM > WB > register file; hit requires stage we=1, stage rc==port address, address!=31.
REQ-018 Legal opcodes: 0x18 LD, 0x19 ST, 0x1B JMP, 0x1D BEQ, 0x1E BNE, 0x1F LDR, 0x20-0x3F with op[3:0] not 0x7/0xF; ill_op=1 for any other opcode, gated by ~stall.
REQ-019 op_jmp/op_beq/op_bne decode from op; all forced 0 when stall, ill_op or irq.
REQ-020 zr = (bypassed A == 0).
REQ-021 br_addr = pc_rf + (lit<<2), modulo 2^32.
REQ-022 j_addr = {A[31:2],2'b00}, with bit31 forced 0 when pc_rf[31]==0 (user mode cannot jump into supervisor).
REQ-023 irq = irq_in & ~pc_rf[31] & ~stall.
REQ-024 ir_src_rf: EXCEPT if irq|ill_op; else NOP if op_jmp | (op_beq&zr) | (op_bne&~zr); else DATA.
REQ-025 stall=1 when alu_ld & alu_we & alu_rc!=31 & alu_rc matches a used port address of ir_rf.
REQ-026 ALU-stage regs load every cycle: stall or ill_op -> ir_alu<=`INST_NOP; else ir_alu<=ir_rf, pc_alu<=pc_rf.
REQ-027 a_alu = bypassed A; pc_rf for LDR.
REQ-028 b_alu = lit for literal ALU ops, LD, ST; lit<<2 for LDR; bypassed B otherwise.
REQ-029 d_alu = bypassed B for ST; pc_rf (link) for JMP/BEQ/BNE; 0 otherwise.
REQ-030 Priority: stall suppresses irq and control transfers; ill_op overrides branches; irq with ill_op -> single EXCEPT.

Reset
REQ-031 rst: pc_rf<=`PC_RESET_ADDR, ir_rf<=`INST_NOP, ir_alu<=`INST_NOP, pc_alu/a_alu/b_alu/d_alu<=0.
REQ-032 After reset: stall=0, ill_op=0, op_*=0, ir_src_rf=`IR_SRC_DATA, irq=0 (`PC_RESET_ADDR bit31=1).
REQ-033 rst asserted mid-stall clears stall next cycle; register-file contents preserved.

Configuration
REQ-034 Macro BYPASS_EN defined: bypass per REQ-017, stall only per REQ-025.
REQ-035 BYPASS_EN undefined: no bypass; stall=1 whenever any ALU/MEM/WB stage with we=1, rc!=31 matches a used port address; REQ-026 bubble rule applies.

Verification
REQ-036 WB write R5=0x1234 then ADD R6,R5,R5 in RF -> a_alu=b_alu=0x1234; R31 read -> 0 despite wb_rc=31 write.
REQ-037 alu_rc=3 alu_data=7, mem_rc=3 mem_data=9, ADDC R1,R3,1 -> a_alu=7, b_alu=1.
REQ-038 alu_ld=1 alu_rc=2, SUB R4,R2,R1 in RF -> stall=1 one cycle, ir_alu=`INST_NOP, then a_alu=mem_data.
REQ-039 BEQ R0, lit=-2, pc_rf=0x100, R0=0 -> op_beq=1, zr=1, br_addr=0xF8, ir_src_rf=NOP, d_alu=0x100.
REQ-040 opcode 0x00 in RF -> ill_op=1, ir_src_rf=EXCEPT, op_*=0, ir_alu=`INST_NOP.
REQ-041 irq_in=1 with pc_rf=0x200 -> irq=1, ir_src_rf=EXCEPT; pc_rf=0x80000200 -> irq=0.
